menu_select: RTL and testbench

MENU_SELECT -- requirements
Module: menu_select

---
 rtl/menu_pkg.sv | 31 +++
 rtl/btn_edge.sv | 32 +++
 rtl/menu_select.sv | 126 ++++++++++++
 tb/tb_menu_select.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared geometry and colour constants for the menu highlight overlay.
package menu_pkg;

  localparam int unsigned BoxHMin  = 362;
  localparam int unsigned BoxHMax  = 674;
  localparam int unsigned BoxVSize = 100;
  localparam int unsigned BorderW  = 3;

  localparam logic [11:0] HlRgbDefault = 12'hff0;

  function automatic logic [10:0] box_top(input logic [1:0] idx);
    case (idx)
      2'd0:    return 11'd46;
      2'd1:    return 11'd238;
      2'd2:    return 11'd430;
      default: return 11'd622;
    endcase
  endfunction

  // True when (h, v) lies on the BorderW-wide frame of the box whose top row is top.
  function automatic logic in_border(input logic [10:0] h, input logic [10:0] v,
                                     input logic [10:0] top);
    logic in_h, in_v, edge_h, edge_v;
    in_h   = (h >= 11'(BoxHMin)) && (h <= 11'(BoxHMax));
    in_v   = (v >= top) && (v <= top + 11'(BoxVSize));
    edge_h = (h <= 11'(BoxHMin + BorderW - 1)) || (h >= 11'(BoxHMax - BorderW + 1));
    edge_v = (v <= top + 11'(BorderW - 1)) || (v >= top + 11'(BoxVSize - BorderW + 1));
    return in_h && in_v && (edge_h || edge_v);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser plus rising-edge detector producing a registered one-cycle pulse.
module btn_edge (
  input  logic pclk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic       sync1_q, sync2_q, prev_q, pulse_q;
  logic [1:0] warm_q;

  // Pulses are masked until the chain has refilled after reset, so a button
  // held through reset is not mistaken for a fresh press.
  always_ff @(posedge pclk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= (warm_q == 2'd3) && sync2_q && !prev_q;
      warm_q  <= (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/menu_select.sv
// Menu selection stage: button-driven highlight box overlaid on the pattern with 1-cycle delay.
// Define MENU_SELECT_BLINK_EN to blink the highlight (16 frames on, 16 off).
module menu_select
  import menu_pkg::*;
#(
  parameter int unsigned N_OPTIONS = 4,
  parameter logic [11:0] HL_RGB    = HlRgbDefault
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_enter,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [1:0]  sel_idx,
  output logic        opt_valid,
  output logic [1:0]  opt_idx
);

  localparam logic [1:0] LastIdx = 2'(N_OPTIONS - 1);

  logic        up_p, down_p, enter_p;
  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [11:0] rgb_q, rgb_d;
  logic [1:0]  sel_pend_q, sel_pend_d;
  logic [1:0]  sel_idx_q, sel_idx_d;
  logic        opt_valid_q;
  logic [1:0]  opt_idx_q, opt_idx_d;
  logic        vblnk_rise, hl_show;

  btn_edge u_btn_up    (.pclk(pclk), .rst(rst), .btn_i(btn_up),    .pulse_o(up_p));
  btn_edge u_btn_down  (.pclk(pclk), .rst(rst), .btn_i(btn_down),  .pulse_o(down_p));
  btn_edge u_btn_enter (.pclk(pclk), .rst(rst), .btn_i(btn_enter), .pulse_o(enter_p));

  // vblnk_q is the previous vblnk_in, so it doubles as the edge-detect history.
  assign vblnk_rise = vblnk_in && !vblnk_q;

`ifdef MENU_SELECT_BLINK_EN
  logic [4:0] frame_cnt_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_cnt_q <= 5'd0;
    end else if (vblnk_rise) begin
      frame_cnt_q <= frame_cnt_q + 5'd1;
    end
  end

  assign hl_show = !frame_cnt_q[4];
`else
  assign hl_show = 1'b1;
`endif

  always_comb begin
    sel_pend_d = sel_pend_q;
    if (up_p && !down_p) begin
      sel_pend_d = (sel_pend_q == 2'd0) ? LastIdx : sel_pend_q - 2'd1;
    end else if (down_p && !up_p) begin
      sel_pend_d = (sel_pend_q == LastIdx) ? 2'd0 : sel_pend_q + 2'd1;
    end
  end

  always_comb begin
    sel_idx_d = vblnk_rise ? sel_pend_q : sel_idx_q;
    opt_idx_d = enter_p ? sel_pend_q : opt_idx_q;
    rgb_d     = rgb_in;
    if (!hblnk_in && !vblnk_in && hl_show &&
        in_border(hcount_in, vcount_in, box_top(sel_idx_q))) begin
      rgb_d = HL_RGB;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      rgb_q       <= '0;
      sel_pend_q  <= '0;
      sel_idx_q   <= '0;
      opt_valid_q <= 1'b0;
      opt_idx_q   <= '0;
    end else begin
      hcount_q    <= hcount_in;
      vcount_q    <= vcount_in;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      hblnk_q     <= hblnk_in;
      vblnk_q     <= vblnk_in;
      rgb_q       <= rgb_d;
      sel_pend_q  <= sel_pend_d;
      sel_idx_q   <= sel_idx_d;
      opt_valid_q <= enter_p;
      opt_idx_q   <= opt_idx_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign hblnk_out  = hblnk_q;
  assign vblnk_out  = vblnk_q;
  assign rgb_out    = rgb_q;
  assign sel_idx    = sel_idx_q;
  assign opt_valid  = opt_valid_q;
  assign opt_idx    = opt_idx_q;

endmodule

// File: tb/tb_menu_select.sv
// Self-checking bench for menu_select against a frame-level behavioural model.
module tb_menu_select;

  localparam int unsigned NOpt = 4;
  localparam logic [11:0] Hl   = 12'hff0;

  logic        pclk, rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        btn_up, btn_down, btn_enter;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [1:0]  sel_idx, opt_idx;
  logic        opt_valid;

  int vectors = 0;
  int miscompares = 0;

  // Model state: pending choice, displayed choice, frames seen.
  int m_pend, m_sel, m_frames;
  bit vb_prev;

  menu_select #(.N_OPTIONS(NOpt), .HL_RGB(Hl)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .sel_idx(sel_idx), .opt_valid(opt_valid), .opt_idx(opt_idx)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [11:0] exp_rgb(input int h, input int v, input bit hb, input bit vb,
                                          input logic [11:0] rgb);
    int top;
    top = 46 + 192 * m_sel;
    if (hb || vb) return rgb;
`ifdef MENU_SELECT_BLINK_EN
    if (((m_frames / 16) % 2) == 1) return rgb;
`endif
    if (h < 362 || h > 674 || v < top || v > top + 100) return rgb;
    if (h <= 364 || h >= 672 || v <= top + 2 || v >= top + 98) return Hl;
    return rgb;
  endfunction

  task automatic cycle();
    bit rise;
    rise    = vblnk_in && !vb_prev;
    vb_prev = vblnk_in;
    @(posedge pclk);
    #1;
    if (rst) begin
      vb_prev = 1'b0;
    end else if (rise) begin
      m_sel = m_pend;
      m_frames++;
    end
  endtask

  task automatic vblank_pulse();
    vblnk_in = 1'b1;
    repeat (3) cycle();
    vblnk_in = 1'b0;
    repeat (2) cycle();
  endtask

  // Press the given buttons together, then idle; reports confirm strobes seen.
  task automatic press(input bit up, input bit dn, input bit en,
                       output int nvalid, output logic [1:0] idx);
    nvalid = 0;
    idx = 2'bxx;
    btn_up = up;
    btn_down = dn;
    btn_enter = en;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_enter = 1'b0;
      end
      cycle();
      if (opt_valid === 1'b1) begin
        nvalid++;
        idx = opt_idx;
      end
    end
    if (up && !dn) m_pend = (m_pend + NOpt - 1) % NOpt;
    if (dn && !up) m_pend = (m_pend + 1) % NOpt;
  endtask

  task automatic test_reset();
    int nv;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    rgb_in = '0; btn_up = 0; btn_enter = 0;
    btn_down = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
           sel_idx, opt_valid, opt_idx} !== 43'd0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %h/%h/%b%b%b%b/%h/%h/%b/%h required all 0",
                 i, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                 rgb_out, sel_idx, opt_valid, opt_idx);
      end
    end
    m_pend = 0; m_sel = 0; m_frames = 0; vb_prev = 1'b0;
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 6) btn_down = 1'b0;
      cycle();
      if (opt_valid === 1'b1) nv++;
    end
    vectors++;
    if (nv != 0) begin
      miscompares++;
      $display("FAIL reset_no_valid: got %0d strobes required 0", nv);
    end
    vblank_pulse();
    vectors++;
    if (sel_idx !== 2'(m_sel)) begin
      miscompares++;
      $display("FAIL reset_held_button: sel_idx got %0d required %0d", sel_idx, m_sel);
    end
  endtask

  task automatic test_down_midframe();
    int nv;
    logic [1:0] idx;
    logic [11:0] exp;
    press(1'b0, 1'b1, 1'b0, nv, idx);
    vectors++;
    if (sel_idx !== 2'(m_sel)) begin
      miscompares++;
      $display("FAIL down_sel_held: sel_idx got %0d required %0d", sel_idx, m_sel);
    end
    press(1'b0, 1'b0, 1'b1, nv, idx);
    vectors++;
    if (nv != 1 || idx !== 2'(m_pend)) begin
      miscompares++;
      $display("FAIL down_pend: strobes %0d idx %0d required 1 / %0d", nv, idx, m_pend);
    end
    vblank_pulse();
    vectors++;
    if (sel_idx !== 2'(m_sel)) begin
      miscompares++;
      $display("FAIL down_sel_update: sel_idx got %0d required %0d", sel_idx, m_sel);
    end
    for (int k = 0; k < 2; k++) begin
      hcount_in = 11'd362;
      vcount_in = (k == 0) ? 11'd238 : 11'd46;
      rgb_in = 12'($urandom);
      exp = exp_rgb(int'(hcount_in), int'(vcount_in), 1'b0, 1'b0, rgb_in);
      cycle();
      vectors++;
      if (rgb_out !== exp) begin
        miscompares++;
        $display("FAIL down_pixel (362,%0d): rgb got %h required %h", vcount_out, rgb_out, exp);
      end
    end
  endtask

  task automatic test_wrap();
    int nv;
    logic [1:0] idx;
    press(1'b1, 1'b0, 1'b0, nv, idx);
    vblank_pulse();
    press(1'b1, 1'b0, 1'b0, nv, idx);
    vblank_pulse();
    vectors++;
    if (sel_idx !== 2'(m_sel) || m_sel != 3) begin
      miscompares++;
      $display("FAIL wrap_up: sel_idx got %0d required %0d", sel_idx, m_sel);
    end
    repeat (4) press(1'b0, 1'b1, 1'b0, nv, idx);
    vblank_pulse();
    vectors++;
    if (sel_idx !== 2'(m_sel)) begin
      miscompares++;
      $display("FAIL wrap_down4: sel_idx got %0d required %0d", sel_idx, m_sel);
    end
  endtask

  task automatic test_simultaneous();
    int nv;
    logic [1:0] idx;
    press(1'b1, 1'b1, 1'b0, nv, idx);
    press(1'b0, 1'b0, 1'b1, nv, idx);
    vectors++;
    if (nv != 1 || idx !== 2'(m_pend)) begin
      miscompares++;
      $display("FAIL simultaneous: strobes %0d idx %0d required 1 / %0d", nv, idx, m_pend);
    end
  endtask

  task automatic test_enter();
    int nv;
    logic [1:0] idx;
    press(1'b1, 1'b0, 1'b0, nv, idx);
    press(1'b0, 1'b0, 1'b1, nv, idx);
    vectors++;
    if (nv != 1 || idx !== 2'(m_pend)) begin
      miscompares++;
      $display("FAIL enter_plain: strobes %0d idx %0d required 1 / %0d", nv, idx, m_pend);
    end
    press(1'b0, 1'b1, 1'b1, nv, idx);
    vectors++;
    if (nv != 1 || idx !== 2'd2) begin
      miscompares++;
      $display("FAIL enter_with_down: strobes %0d idx %0d required 1 / 2", nv, idx);
    end
    repeat (5) cycle();
    vectors++;
    if (opt_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL enter_hold: opt_idx got %0d required 2", opt_idx);
    end
    press(1'b0, 1'b0, 1'b1, nv, idx);
    vectors++;
    if (nv != 1 || idx !== 2'(m_pend)) begin
      miscompares++;
      $display("FAIL enter_after_down: strobes %0d idx %0d required 1 / %0d", nv, idx, m_pend);
    end
  endtask

  task automatic test_random_buttons();
    int nv, pre;
    bit up, dn, en;
    logic [1:0] idx;
    for (int it = 0; it < 16; it++) begin
      up = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
      en = 1'($urandom_range(0, 1));
      pre = m_pend;
      press(up, dn, en, nv, idx);
      vectors++;
      if (nv != int'(en) || (en && idx !== 2'(pre))) begin
        miscompares++;
        $display("FAIL rand_btn it %0d (u%0d d%0d e%0d): strobes %0d idx %0d required %0d / %0d",
                 it, up, dn, en, nv, idx, en, pre);
      end
      if (it % 4 == 3) begin
        vblank_pulse();
        vectors++;
        if (sel_idx !== 2'(m_sel)) begin
          miscompares++;
          $display("FAIL rand_btn_sel it %0d: sel_idx got %0d required %0d", it, sel_idx, m_sel);
        end
      end
    end
  endtask

  task automatic test_latency();
    int h, v;
    bit hs, vs, hb, vb;
    logic [11:0] rgb, exp_c;
    logic [25:0] exp_t;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        h = $urandom_range(350, 690);
        v = $urandom_range(30, 740);
      end else begin
        h = $urandom_range(0, 1300);
        v = $urandom_range(0, 1000);
      end
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      hb = ($urandom_range(0, 7) == 0);
      vb = ($urandom_range(0, 15) == 0);
      rgb = 12'($urandom);
      hcount_in = 11'(h); vcount_in = 11'(v);
      hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
      exp_t = {11'(h), 11'(v), hs, vs, hb, vb};
      exp_c = exp_rgb(h, v, hb, vb, rgb);
      cycle();
      vectors++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== exp_t) begin
        miscompares++;
        $display("FAIL latency_timing it %0d: got %h required %h", it,
                 {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, exp_t);
      end
      vectors++;
      if (rgb_out !== exp_c) begin
        miscompares++;
        $display("FAIL latency_rgb it %0d (%0d,%0d hb%0d vb%0d): got %h required %h",
                 it, h, v, hb, vb, rgb_out, exp_c);
      end
    end
    // Border pixel of the selected box under each blanking flag, then unblanked.
    for (int k = 0; k < 3; k++) begin
      hcount_in = 11'd362;
      vcount_in = 11'(46 + 192 * m_sel);
      hblnk_in = (k == 0);
      vblnk_in = (k == 1);
      rgb = 12'($urandom);
      rgb_in = rgb;
      exp_c = exp_rgb(362, 46 + 192 * m_sel, hblnk_in, vblnk_in, rgb);
      cycle();
      vectors++;
      if (rgb_out !== exp_c || (k < 2 && rgb_out !== rgb)) begin
        miscompares++;
        $display("FAIL blank_border case %0d: got %h required %h", k, rgb_out, exp_c);
      end
    end
    hblnk_in = 1'b0;
    vblnk_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_down_midframe();
    test_wrap();
    test_simultaneous();
    test_enter();
    test_random_buttons();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
